// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: type/opcode encodings, RV major opcodes and
// the decoded bundle carried from decode through the skid buffer to EX.
package id_pkg;

  // Operands are carried at the widest legal XLEN; narrower builds use the low bits.
  localparam int unsigned MaxXlen = 64;

  typedef enum logic [4:0] {
    TypeNone  = 5'b00000,
    TypeArith = 5'b10000,
    TypeLogic = 5'b01000,
    TypeLdSt  = 5'b00100,
    TypeJump  = 5'b00010,
    TypeSys   = 5'b00001
  } inst_type_e;

  typedef enum logic [7:0] {
    OpcNone = 8'h00,
    OpcAdd  = 8'h11,
    OpcSub  = 8'h12,
    OpcSlt  = 8'h13,
    OpcSltu = 8'h14,
    OpcSll  = 8'h15,
    OpcSrl  = 8'h16,
    OpcSra  = 8'h17,
    OpcAnd  = 8'h21,
    OpcOr   = 8'h22,
    OpcXor  = 8'h23
  } inst_opcode_e;

  typedef enum logic [6:0] {
    RvOpImm = 7'b0010011,
    RvOp    = 7'b0110011,
    RvLui   = 7'b0110111,
    RvAuipc = 7'b0010111
  } rv_opcode_e;

  typedef struct packed {
    logic               illegal;
    logic [4:0]         inst_type;
    logic [7:0]         inst_opcode;
    logic               rd_w_ena;
    logic [4:0]         rd_w_addr;
    logic [MaxXlen-1:0] op1;
    logic [MaxXlen-1:0] op2;
  } id_bundle_t;

endpackage

// File: rtl/id_decode.sv
// Combinational RV64I/RV32I integer-ALU decoder: instruction word to id_bundle_t plus the
// register-file read-port controls.
module id_decode
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 64
) (
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            rs1_r_ena,
  output logic [4:0]      rs1_r_addr,
  output logic            rs2_r_ena,
  output logic [4:0]      rs2_r_addr,
  output id_bundle_t      bundle
);

  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [4:0]         rd;
  logic [MaxXlen-1:0] imm_i;
  logic [MaxXlen-1:0] imm_u;
  logic [5:0]         shamt;
  logic [6:0]         sh_f7;
  logic               legal;
  logic               use_rs1;
  logic               use_rs2;
  id_bundle_t         b;

  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign imm_i  = {{(MaxXlen - 12){inst[31]}}, inst[31:20]};
  assign imm_u  = {{(MaxXlen - 32){inst[31]}}, inst[31:12], 12'b0};

  // RV64 shifts take a 6-bit shamt, so inst[25] moves out of the funct field.
  assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
  assign sh_f7 = (XLEN == 64) ? {inst[31:26], 1'b0} : inst[31:25];

  always_comb begin
    b       = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (inst[6:0])
      RvOpImm: begin
        legal       = 1'b1;
        use_rs1     = 1'b1;
        b.op1       = MaxXlen'(rs1_data);
        b.op2       = imm_i;
        b.inst_type = TypeArith;
        case (funct3)
          3'b000: b.inst_opcode = OpcAdd;
          3'b010: b.inst_opcode = OpcSlt;
          3'b011: b.inst_opcode = OpcSltu;
          3'b100: begin
            b.inst_opcode = OpcXor;
            b.inst_type   = TypeLogic;
          end
          3'b110: begin
            b.inst_opcode = OpcOr;
            b.inst_type   = TypeLogic;
          end
          3'b111: begin
            b.inst_opcode = OpcAnd;
            b.inst_type   = TypeLogic;
          end
          3'b001: begin
            b.inst_opcode = OpcSll;
            b.op2         = MaxXlen'(shamt);
            legal         = (sh_f7 == 7'b0);
          end
          default: begin
            b.inst_opcode = inst[30] ? OpcSra : OpcSrl;
            b.op2         = MaxXlen'(shamt);
            legal         = ({sh_f7[6], sh_f7[4:0]} == 6'b0);
          end
        endcase
      end
      RvOp: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        b.op1       = MaxXlen'(rs1_data);
        b.op2       = MaxXlen'(rs2_data);
        b.inst_type = TypeArith;
        legal       = (funct7 == 7'b0) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
          3'b000: b.inst_opcode = inst[30] ? OpcSub : OpcAdd;
          3'b001: b.inst_opcode = OpcSll;
          3'b010: b.inst_opcode = OpcSlt;
          3'b011: b.inst_opcode = OpcSltu;
          3'b100: begin
            b.inst_opcode = OpcXor;
            b.inst_type   = TypeLogic;
          end
          3'b101: b.inst_opcode = inst[30] ? OpcSra : OpcSrl;
          3'b110: begin
            b.inst_opcode = OpcOr;
            b.inst_type   = TypeLogic;
          end
          default: begin
            b.inst_opcode = OpcAnd;
            b.inst_type   = TypeLogic;
          end
        endcase
      end
      RvLui: begin
        legal         = 1'b1;
        b.op2         = imm_u;
        b.inst_type   = TypeArith;
        b.inst_opcode = OpcAdd;
      end
      RvAuipc: begin
        legal         = 1'b1;
        b.op1         = MaxXlen'(pc);
        b.op2         = imm_u;
        b.inst_type   = TypeArith;
        b.inst_opcode = OpcAdd;
      end
      default: ;
    endcase

    // Illegal words travel to EX as an empty bundle with only the flag set.
    if (legal) begin
      b.rd_w_ena  = (rd != 5'd0);
      b.rd_w_addr = (rd != 5'd0) ? rd : 5'd0;
    end else begin
      b       = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
    b.illegal = ~legal;
  end

  assign bundle     = b;
  assign rs1_r_ena  = use_rs1;
  assign rs1_r_addr = use_rs1 ? inst[19:15] : 5'd0;
  assign rs2_r_ena  = use_rs2;
  assign rs2_r_addr = use_rs2 ? inst[24:20] : 5'd0;

endmodule

// File: rtl/id_stage_pipe.sv
// Registered ID stage: combinational decode feeding a 2-entry skid buffer that presents
// bundles to EX over valid/ready, with flush on redirect.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            rs1_r_ena,
  output logic [4:0]      rs1_r_addr,
  output logic            rs2_r_ena,
  output logic [4:0]      rs2_r_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      inst_type,
  output logic [7:0]      inst_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            rd_w_ena,
  output logic [4:0]      rd_w_addr,
  output logic            illegal
);

  id_bundle_t      dec_bundle;
  id_bundle_t      main_q, main_d, skid_q, skid_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, consume;

  id_decode #(
    .XLEN(XLEN),
    .PC_W(PC_W)
  ) u_decode (
    .inst      (in_inst),
    .pc        (in_pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rs1_r_ena (rs1_r_ena),
    .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena (rs2_r_ena),
    .rs2_r_addr(rs2_r_addr),
    .bundle    (dec_bundle)
  );

  // The skid flop is the only thing that can block IF, so ready is just its inverse.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign consume  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    main_pc_d    = main_pc_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume && skid_valid_q) begin
      main_d       = skid_q;
      main_pc_d    = skid_pc_q;
      skid_valid_d = accept;
      if (accept) begin
        skid_d    = dec_bundle;
        skid_pc_d = in_pc;
      end
    end else if (consume || !main_valid_q) begin
      main_valid_d = accept;
      if (accept) begin
        main_d    = dec_bundle;
        main_pc_d = in_pc;
      end
    end else if (accept) begin
      skid_d       = dec_bundle;
      skid_pc_d    = in_pc;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q       <= '0;
      main_pc_q    <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_pc_q    <= main_pc_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_pc      = main_pc_q;
  assign inst_type   = main_q.inst_type;
  assign inst_opcode = main_q.inst_opcode;
  assign op1         = main_q.op1[XLEN-1:0];
  assign op2         = main_q.op2[XLEN-1:0];
  assign rd_w_ena    = main_q.rd_w_ena;
  assign rd_w_addr   = main_q.rd_w_addr;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: a FIFO-level model with a spec-derived decoder checked every
// cycle, plus directed literal checks and an XLEN=32 instance for shift-width rules.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        rs1_r_ena, rs2_r_ena;
  logic [4:0]  rs1_r_addr, rs2_r_addr;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [4:0]  inst_type;
  logic [7:0]  inst_opcode;
  logic [63:0] op1, op2;
  logic        rd_w_ena;
  logic [4:0]  rd_w_addr;
  logic        illegal;

  // XLEN=32 instance
  logic        flush_32 = 1'b0;
  logic        in_valid_32 = 1'b0;
  logic        in_ready_32;
  logic [63:0] in_pc_32 = '0;
  logic [31:0] in_inst_32 = '0;
  logic        rs1_r_ena_32, rs2_r_ena_32;
  logic [4:0]  rs1_r_addr_32, rs2_r_addr_32;
  logic [31:0] rs1_data_32 = '0;
  logic [31:0] rs2_data_32 = '0;
  logic        out_valid_32;
  logic        out_ready_32 = 1'b1;
  logic [63:0] out_pc_32;
  logic [4:0]  inst_type_32;
  logic [7:0]  inst_opcode_32;
  logic [31:0] op1_32, op2_32;
  logic        rd_w_ena_32;
  logic [4:0]  rd_w_addr_32;
  logic        illegal_32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(64), .PC_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .inst_type(inst_type),
    .inst_opcode(inst_opcode), .op1(op1), .op2(op2), .rd_w_ena(rd_w_ena),
    .rd_w_addr(rd_w_addr), .illegal(illegal)
  );

  id_stage_pipe #(.XLEN(32), .PC_W(64)) dut32 (
    .clk(clk), .rst(rst), .flush(flush_32), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .in_pc(in_pc_32), .in_inst(in_inst_32), .rs1_r_ena(rs1_r_ena_32),
    .rs1_r_addr(rs1_r_addr_32), .rs2_r_ena(rs2_r_ena_32), .rs2_r_addr(rs2_r_addr_32),
    .rs1_data(rs1_data_32), .rs2_data(rs2_data_32), .out_valid(out_valid_32),
    .out_ready(out_ready_32), .out_pc(out_pc_32), .inst_type(inst_type_32),
    .inst_opcode(inst_opcode_32), .op1(op1_32), .op2(op2_32), .rd_w_ena(rd_w_ena_32),
    .rd_w_addr(rd_w_addr_32), .illegal(illegal_32)
  );

  typedef struct {
    logic        illegal;
    logic [4:0]  typ;
    logic [7:0]  opc;
    logic        rd_ena;
    logic [4:0]  rd_addr;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] pc;
    logic        r1_ena;
    logic [4:0]  r1_addr;
    logic        r2_ena;
    logic [4:0]  r2_addr;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // funct3 -> {type, opcode} for the ALU table; alt = inst[30] where SUB/SRA apply.
  function automatic logic [12:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? {5'b10000, 8'h12} : {5'b10000, 8'h11};
      3'd1:    return {5'b10000, 8'h15};
      3'd2:    return {5'b10000, 8'h13};
      3'd3:    return {5'b10000, 8'h14};
      3'd4:    return {5'b01000, 8'h23};
      3'd5:    return alt ? {5'b10000, 8'h17} : {5'b10000, 8'h16};
      3'd6:    return {5'b01000, 8'h22};
      default: return {5'b01000, 8'h21};
    endcase
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc,
                                   input logic [63:0] r1, input logic [63:0] r2, input int xlen);
    exp_t        e;
    logic        legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [12:0] to;
    f3 = inst[14:12];
    f7 = inst[31:25];
    rd = inst[11:7];
    e = '{default: 0};
    legal = 1'b0;
    case (inst[6:0])
      7'h13: begin
        legal = 1'b1;
        e.r1_ena = 1'b1;
        e.op1 = r1;
        e.op2 = {{52{inst[31]}}, inst[31:20]};
        to = alu_op(f3, (f3 == 3'd5) && inst[30]);
        {e.typ, e.opc} = to;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (xlen == 64) begin
            e.op2 = 64'(inst[25:20]);
            legal = (f3 == 3'd1) ? (inst[31:26] == 6'd0) : (inst[31] == 1'b0 && inst[29:26] == 4'd0);
          end else begin
            e.op2 = 64'(inst[24:20]);
            legal = (f3 == 3'd1) ? (inst[31:25] == 7'd0) : (inst[31] == 1'b0 && inst[29:25] == 5'd0);
          end
        end
      end
      7'h33: begin
        e.r1_ena = 1'b1;
        e.r2_ena = 1'b1;
        e.op1 = r1;
        e.op2 = r2;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        to = alu_op(f3, inst[30]);
        {e.typ, e.opc} = to;
      end
      7'h37, 7'h17: begin
        legal = 1'b1;
        e.typ = 5'b10000;
        e.opc = 8'h11;
        e.op1 = (inst[6:0] == 7'h17) ? pc : 64'd0;
        e.op2 = {{32{inst[31]}}, inst[31:12], 12'h000};
      end
      default: ;
    endcase
    if (!legal) begin
      e = '{default: 0};
      e.illegal = 1'b1;
    end else begin
      e.r1_addr = e.r1_ena ? inst[19:15] : 5'd0;
      e.r2_addr = e.r2_ena ? inst[24:20] : 5'd0;
      e.rd_ena  = (rd != 5'd0);
      e.rd_addr = e.rd_ena ? rd : 5'd0;
    end
    if (xlen == 32) begin
      e.op1 = e.op1 & 64'hFFFF_FFFF;
      e.op2 = e.op2 & 64'hFFFF_FFFF;
    end
    e.pc = pc;
    return e;
  endfunction

  // Model: ordered list of bundles held by the stage (at most two).
  exp_t mq[$];
  exp_t cur, hd;

  task automatic model_step();
    bit acc, con;
    acc = in_valid && (mq.size() < 2) && !flush;
    con = (mq.size() != 0) && out_ready;
    if (flush) mq.delete();
    else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(ref_dec(in_inst, in_pc, rs1_data, rs2_data, 64));
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) mq.delete();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst) begin
      cur = ref_dec(in_inst, in_pc, rs1_data, rs2_data, 64);
      check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        hd = mq[0];
        check("out_pc", out_pc, hd.pc);
        check("illegal", 64'(illegal), 64'(hd.illegal));
        check("inst_type", 64'(inst_type), 64'(hd.typ));
        check("inst_opcode", 64'(inst_opcode), 64'(hd.opc));
        check("op1", op1, hd.op1);
        check("op2", op2, hd.op2);
        check("rd_w_ena", 64'(rd_w_ena), 64'(hd.rd_ena));
        check("rd_w_addr", 64'(rd_w_addr), 64'(hd.rd_addr));
      end
      check("rs1_r_ena", 64'(rs1_r_ena), 64'(cur.r1_ena));
      check("rs1_r_addr", 64'(rs1_r_addr), 64'(cur.r1_addr));
      check("rs2_r_ena", 64'(rs2_r_ena), 64'(cur.r2_ena));
      check("rs2_r_addr", 64'(rs2_r_addr), 64'(cur.r2_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] r1,
                       input logic [63:0] r2);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r, w;
    logic [2:0]  f3;
    int          sel;
    r   = $urandom;
    f3  = r[14:12];
    sel = $urandom_range(0, 9);
    w   = r;
    if (sel <= 3) begin
      w[6:0] = 7'h13;
      if ((f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 3) != 0)
        w[31:26] = {1'b0, (f3 == 3'd5) ? r[31] : 1'b0, 4'd0};
    end else if (sel <= 6) begin
      w[6:0] = 7'h33;
      case ($urandom_range(0, 3))
        0, 1:    w[31:25] = 7'h00;
        2:       w[31:25] = 7'h20;
        default: ;
      endcase
    end else if (sel == 7) w[6:0] = 7'h37;
    else if (sel == 8) w[6:0] = 7'h17;
    return w;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_pc", out_pc, 64'd0);
    check("reset op1", op1, 64'd0);
    check("reset op2", op2, 64'd0);
    check("reset inst_opcode", 64'(inst_opcode), 64'd0);
    check("reset rd_w_addr", 64'(rd_w_addr), 64'd0);
    tick();

    // addi x1,x2,-1
    offer(32'hFFF10093, 64'h1000, 64'd5, 64'd0);
    tick();
    in_valid = 1'b0;
    check("addi out_valid", 64'(out_valid), 64'd1);
    check("addi inst_type", 64'(inst_type), 64'h10);
    check("addi inst_opcode", 64'(inst_opcode), 64'h11);
    check("addi op1", op1, 64'd5);
    check("addi op2", op2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi rd_w_addr", 64'(rd_w_addr), 64'd1);

    // sub x3,x4,x5 then lui x6,0x12345
    offer(32'h405201B3, 64'h1004, 64'd9, 64'h0123_4567_89AB_CDEF);
    tick();
    offer(32'h12345337, 64'h1008, 64'd9, 64'd7);
    #1;
    check("lui rs1_r_ena", 64'(rs1_r_ena), 64'd0);
    check("sub inst_opcode", 64'(inst_opcode), 64'h12);
    check("sub op2", op2, 64'h0123_4567_89AB_CDEF);
    tick();
    in_valid = 1'b0;
    check("lui op2", op2, 64'h0000_0000_1234_5000);
    check("lui op1", op1, 64'd0);
    tick();

    // Stall with three offered
    out_ready = 1'b0;
    offer(32'h00108093, 64'h2000, 64'd1, 64'd0);
    tick();
    offer(32'h00210113, 64'h2004, 64'd2, 64'd0);
    tick();
    check("stall in_ready", 64'(in_ready), 64'd0);
    offer(32'h00318193, 64'h2008, 64'd3, 64'd0);
    tick();
    check("stall hold in_ready", 64'(in_ready), 64'd0);
    check("stall hold out_pc", out_pc, 64'h2000);
    out_ready = 1'b1;
    tick();
    check("release out_pc 2", out_pc, 64'h2004);
    tick();
    in_valid = 1'b0;
    check("release out_pc 3", out_pc, 64'h2008);
    tick();
    check("drained out_valid", 64'(out_valid), 64'd0);

    // Flush with both entries full and a new instruction offered
    out_ready = 1'b0;
    offer(32'h00400213, 64'h3000, 64'd0, 64'd0);
    tick();
    offer(32'h00500293, 64'h3004, 64'd0, 64'd0);
    tick();
    offer(32'h00600313, 64'h3008, 64'd0, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    tick();
    check("flush no ghost", 64'(out_valid), 64'd0);

    // Illegal opcode, then canonical nop
    offer(32'h0000007F, 64'h4000, 64'd11, 64'd12);
    tick();
    check("ill illegal", 64'(illegal), 64'd1);
    check("ill inst_type", 64'(inst_type), 64'd0);
    check("ill inst_opcode", 64'(inst_opcode), 64'd0);
    check("ill rd_w_ena", 64'(rd_w_ena), 64'd0);
    check("ill op1", op1, 64'd0);
    offer(32'h00000013, 64'h4004, 64'd11, 64'd12);
    tick();
    in_valid = 1'b0;
    check("nop illegal", 64'(illegal), 64'd0);
    check("nop rd_w_ena", 64'(rd_w_ena), 64'd0);
    check("nop inst_type", 64'(inst_type), 64'h10);

    // XLEN=32: srai x1,x1,31, then shamt[5] set
    in_valid_32 = 1'b1;
    in_inst_32  = 32'h41F0D093;
    rs1_data_32 = 32'hDEAD_BEEF;
    tick();
    check("x32 srai op2", 64'(op2_32), 64'd31);
    check("x32 srai opcode", 64'(inst_opcode_32), 64'h17);
    check("x32 srai illegal", 64'(illegal_32), 64'd0);
    in_inst_32 = 32'h43F0D093;
    tick();
    in_valid_32 = 1'b0;
    check("x32 shamt5 illegal", 64'(illegal_32), 64'd1);
    check("x32 shamt5 opcode", 64'(inst_opcode_32), 64'd0);

    // Randomized stream against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      rs1_data  = {$urandom, $urandom};
      rs2_data  = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      if (c == 1500) begin
        rst = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
      end
      tick();
    end

    in_valid = 1'b0;
    flush = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered, handshaked successor of the single-instruction decode stage. It decodes the RV64I integer-ALU subset (OP-IMM, OP, LUI, AUIPC) into the existing `inst_type` / `inst_opcode` encoding and drives the register-file read ports combinationally. Results are held in a 2-entry skid buffer, and the buffer feeds EX over a valid/ready interface. It sits between the IF stage and the EX stage, and supports flush on redirect.

## Interface
- `XLEN`, 64: register and operand width; 32 and 64 are legal.
- `PC_W`, 64: PC width.

- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-low reset.
- `flush`  in  1: drop all held and incoming instructions.
- `in_valid`  in  1: IF offers an instruction.
- `in_ready`  out  1: stage can accept; registered.
- `in_pc`  in  PC_W: PC of the offered instruction.
- `in_inst`  in  32: instruction word.
- `rs1_r_ena`, `rs2_r_ena`  out  1: regfile read enables; combinational from `in_inst`.
- `rs1_r_addr`, `rs2_r_addr`  out  5: regfile read addresses.
- `rs1_data`, `rs2_data`  in  XLEN: regfile read data, same cycle.
- `out_valid`  out  1: EX bundle valid.
- `out_ready`  in  1: EX accepts.
- `out_pc`  out  PC_W: PC of the EX bundle.
- `inst_type`  out  5: 10000 arith, 01000 logic, 00100 ld/st, 00010 jump, 00001 sys.
- `inst_opcode`  out  8: operation code (package constants).
- `op1`, `op2`  out  XLEN: operands.
- `rd_w_ena`  out  1: writeback enable.
- `rd_w_addr`  out  5: writeback address.
- `illegal`  out  1: instruction outside the supported subset.

## Operation
- Decode is combinational on `in_inst`. The result is captured only on accept (`in_valid & in_ready & ~flush`).
- OP-IMM, func3 000/010/011/100/110/111/001/101:
  - ops: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (`inst[30]` selects SRAI).
  - `op1` = `rs1_data`; `op2` = imm[11:0] sign-extended to XLEN.
  - For shifts, `op2` = shamt zero-extended; shamt is 6 bits when XLEN=64, 5 bits when XLEN=32.
- OP: ADD/SUB (`inst[30]`), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. `op1` = `rs1_data`, `op2` = `rs2_data`.
- LUI: `op1` = 0; `op2` = {imm[31:12], 12'b0} sign-extended. Decoded as ADD; rs1/rs2 reads disabled.
- AUIPC: `op1` = `in_pc` zero-extended; `op2` is the same immediate as LUI. Decoded as ADD.
- `inst_type`: arith for add/sub/slt/sltu/shifts/lui/auipc; logic for and/or/xor.
- Read enables and addresses are 0 when the operand is unused.
- `rd_w_ena` = legal & (rd ≠ 0). `rd_w_addr` = rd when enabled, else 0.
- Illegal instruction (any other opcode, or funct7 not matching the spec):
  - `illegal` = 1, `inst_type` = 0, `inst_opcode` = 0, `rd_w_ena` = 0, operands 0.
  - It still occupies a slot and is passed to EX.
- Skid buffer has a main register (drives outputs) and a skid register.
- On accept:
  - If main is empty, or main is being consumed this cycle (`out_valid & out_ready`) with skid empty, the new bundle loads into main.
  - Otherwise it loads into skid.
- On consume with skid full: skid moves to main, and any accepted bundle moves to skid in the same edge.
- `in_ready` = ~skid_valid, registered.
- `flush` clears main and skid valids at the next edge and wins over every simultaneous accept or consume. `in_ready` is 1 the cycle after a flush.

## Timing
- Latency: accept at edge N, `out_valid` at N+1.
- Throughput: 1 per cycle while `out_ready` = 1.
- Reset (`rst` low, async):
  - `out_valid` = 0, `in_ready` = 1 after release.
  - All registered bundle fields are 0.
  - Reset mid-stream discards held bundles.
- Output fields hold stable while `out_valid & ~out_ready`.
- A bundle is never lost or duplicated.
- Order is preserved: main always holds the older entry.
- Both entries full ⇒ `in_ready` = 0 the following cycle. A back-to-back stream under stall fills main, then skid, then stops.

## Structure
- Shared package `id_pkg` holds:
  - `inst_type` constants.
  - `inst_opcode` constants: ADD 8'h11, SUB 8'h12, SLT 8'h13, SLTU 8'h14, SLL 8'h15, SRL 8'h16, SRA 8'h17, AND 8'h21, OR 8'h22, XOR 8'h23.
  - RV opcode constants.
  - Packed `id_bundle_t` struct.
- Sub-module `id_decode`: purely combinational inst → `id_bundle_t`. The top level holds the skid buffer.

## Test plan
- Reset, then `addi x1,x2,-1` (0xFFF10093) with `rs1_data`=5, `out_ready`=1 → next cycle:
  - `inst_type`=10000, `inst_opcode`=8'h11.
  - `op1`=5, `op2`=0xFFFF_FFFF_FFFF_FFFF.
  - `rd_w_addr`=1.
- `sub x3,x4,x5` then `lui x6,0x12345` back-to-back → opcode 8'h12, `op2`=`rs2_data`; then `op2`=0x0000_0000_1234_5000, `rs1_r_ena`=0.
- `out_ready`=0 while 3 instructions are offered → first in main, second in skid, `in_ready`=0. Release stall → all three emerge in order, no gaps beyond one.
- `flush` asserted with both entries full and `in_valid`=1 → `out_valid`=0 next cycle, `in_ready`=1, and the flushed-cycle instruction never appears.
- Opcode 0x7F and `addi x0,x0,0` → `illegal`=1 with zeroed fields; nop has `illegal`=0, `rd_w_ena`=0.
- XLEN=32 build, `srai x1,x1,31` → `op2`=31, opcode 8'h17; the same encoding with shamt[5]=1 is flagged illegal.
